// File: rtl/mem_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_req_arbiter_if
// Downstream memory request bus between the arbiter and the address-decode /
// memory-map block. It carries a ren/wen/ack four-phase handshake.
//   m_addr, m_wdata : 32-bit address / write data (arbiter -> memory map)
//   m_ren, m_wen    : read / write request levels (arbiter -> memory map)
//   m_ack           : acknowledge level             (memory map -> arbiter)
//   m_rdata         : read data, valid while m_ack  (memory map -> arbiter)
// Modports: master = arbiter side, slave = memory-map side.
// ----------------------------------------------------------------------------
interface mem_req_arbiter_if;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_ren;
   logic        m_wen;
   logic        m_ack;
   logic [31:0] m_rdata;

   modport master (
      output m_addr,
      output m_wdata,
      output m_ren,
      output m_wen,
      input  m_ack,
      input  m_rdata
   );

   modport slave (
      input  m_addr,
      input  m_wdata,
      input  m_ren,
      input  m_wen,
      output m_ack,
      output m_rdata
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// mem_req_arbiter
// Three-port round-robin arbiter. Port 0 is the DMA engine, port 1 is the CPU
// data port and port 2 is the CPU instruction-fetch port. They share one
// downstream memory request port. The arbiter latches the winning command,
// runs the full downstream four-phase handshake, and returns the read data
// and ack to the winner. A bounded wait aborts a hung downstream transaction.
// Ports:
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   rN_addr/rN_wdata      : port N command (N = 0..2), held until rN_ack
//   rN_ren/rN_wen         : port N read/write request levels
//   rN_ack                : port N acknowledge level
//   rdata                 : read data of the current/last response
//   grant                 : one-hot owner of the downstream port, 0 when idle
//   bus_err               : one-cycle pulse on timeout abort
//   err_count             : saturating count of timeouts
//   mbus                  : downstream request bus (master side)
// ----------------------------------------------------------------------------
module mem_req_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] r0_addr,
   input  logic [31:0] r0_wdata,
   input  logic        r0_ren,
   input  logic        r0_wen,
   output logic        r0_ack,
   input  logic [31:0] r1_addr,
   input  logic [31:0] r1_wdata,
   input  logic        r1_ren,
   input  logic        r1_wen,
   output logic        r1_ack,
   input  logic [31:0] r2_addr,
   input  logic [31:0] r2_wdata,
   input  logic        r2_ren,
   input  logic        r2_wen,
   output logic        r2_ack,
   output logic [31:0] rdata,
   output logic [2:0]  grant,
   output logic        bus_err,
   output logic [7:0]  err_count,
   mem_req_arbiter_if.master mbus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Last counter value before the abort fires.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   // First requester found scanning ptr, ptr+1, ptr+2 (mod 3).
   function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
      logic [2:0] res;
      case (ptr)
         2'd1:    res = req[1] ? 3'b010 : (req[2] ? 3'b100 : (req[0] ? 3'b001 : 3'b000));
         2'd2:    res = req[2] ? 3'b100 : (req[0] ? 3'b001 : (req[1] ? 3'b010 : 3'b000));
         default: res = req[0] ? 3'b001 : (req[1] ? 3'b010 : (req[2] ? 3'b100 : 3'b000));
      endcase
      return res;
   endfunction

   state_t      state_q,   state_d;
   logic [1:0]  ptr_q,     ptr_d;
   logic [2:0]  grant_q,   grant_d;
   logic [2:0]  ack_q,     ack_d;
   logic [15:0] cnt_q,     cnt_d;
   logic [31:0] rdata_q,   rdata_d;
   logic        bus_err_q, bus_err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic [31:0] m_addr_q,  m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic        m_ren_q,   m_ren_d;
   logic        m_wen_q,   m_wen_d;

   logic [2:0]  req_s;
   logic [2:0]  pick_s;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_wdata_s;
   logic        sel_ren_s;
   logic        sel_wen_s;

   assign req_s  = {r2_ren | r2_wen, r1_ren | r1_wen, r0_ren | r0_wen};
   assign pick_s = rr_pick(req_s, ptr_q);

   // Command mux for the port selected by the round-robin scan.
   always_comb begin
      sel_addr_s  = 32'h0000_0000;
      sel_wdata_s = 32'h0000_0000;
      sel_ren_s   = 1'b0;
      sel_wen_s   = 1'b0;
      case (pick_s)
         3'b001: begin
            sel_addr_s  = r0_addr;
            sel_wdata_s = r0_wdata;
            sel_ren_s   = r0_ren;
            sel_wen_s   = r0_wen;
         end
         3'b010: begin
            sel_addr_s  = r1_addr;
            sel_wdata_s = r1_wdata;
            sel_ren_s   = r1_ren;
            sel_wen_s   = r1_wen;
         end
         3'b100: begin
            sel_addr_s  = r2_addr;
            sel_wdata_s = r2_wdata;
            sel_ren_s   = r2_ren;
            sel_wen_s   = r2_wen;
         end
         default: begin
            sel_addr_s  = 32'h0000_0000;
            sel_wdata_s = 32'h0000_0000;
            sel_ren_s   = 1'b0;
            sel_wen_s   = 1'b0;
         end
      endcase
   end

   // Next-state and next-output logic of the arbitration FSM.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      ack_d     = ack_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      bus_err_d = 1'b0;
      err_cnt_d = err_cnt_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_ren_d   = m_ren_q;
      m_wen_d   = m_wen_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_s != 3'b000) begin
               grant_d   = pick_s;
               m_addr_d  = sel_addr_s;
               m_wdata_d = sel_wdata_s;
               m_ren_d   = sel_ren_s;
               // A request with both ren and wen high is treated as a read.
               m_wen_d   = sel_wen_s & ~sel_ren_s;
               cnt_d     = 16'd0;
               state_d   = ST_BUSY;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mbus.m_ack) begin
               rdata_d = m_ren_q ? mbus.m_rdata : 32'h0000_0000;
               m_ren_d = 1'b0;
               m_wen_d = 1'b0;
               state_d = ST_DRAIN;
            end else if (cnt_q == TO_LAST) begin
               rdata_d   = 32'h0000_0000;
               m_ren_d   = 1'b0;
               m_wen_d   = 1'b0;
               bus_err_d = 1'b1;
               err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);
               state_d   = ST_DRAIN;
            end else begin
               cnt_d   = cnt_q + 16'd1;
               state_d = ST_BUSY;
            end
         end
         ST_DRAIN: begin
            // Complete the downstream four-phase cycle before answering.
            if (!mbus.m_ack) begin
               ack_d   = grant_q;
               state_d = ST_RESP;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_RESP: begin
            if ((grant_q & req_s) == 3'b000) begin
               ack_d   = 3'b000;
               grant_d = 3'b000;
               case (grant_q)
                  3'b001:  ptr_d = 2'd1;
                  3'b010:  ptr_d = 2'd2;
                  3'b100:  ptr_d = 2'd0;
                  default: ptr_d = 2'd0;
               endcase
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; asynchronous reset clears everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 2'd0;
         grant_q   <= 3'b000;
         ack_q     <= 3'b000;
         cnt_q     <= 16'd0;
         rdata_q   <= 32'h0000_0000;
         bus_err_q <= 1'b0;
         err_cnt_q <= 8'd0;
         m_addr_q  <= 32'h0000_0000;
         m_wdata_q <= 32'h0000_0000;
         m_ren_q   <= 1'b0;
         m_wen_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         bus_err_q <= bus_err_d;
         err_cnt_q <= err_cnt_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_ren_q   <= m_ren_d;
         m_wen_q   <= m_wen_d;
      end
   end

   assign r0_ack       = ack_q[0];
   assign r1_ack       = ack_q[1];
   assign r2_ack       = ack_q[2];
   assign rdata        = rdata_q;
   assign grant        = grant_q;
   assign bus_err      = bus_err_q;
   assign err_count    = err_cnt_q;
   assign mbus.m_addr  = m_addr_q;
   assign mbus.m_wdata = m_wdata_q;
   assign mbus.m_ren   = m_ren_q;
   assign mbus.m_wen   = m_wen_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_req_arbiter
// Directed bench for mem_req_arbiter. A small downstream model acks one cycle
// after a request and drops one cycle after the request falls. Reads return
// 0x3C080013 for address 0xBFC00000 and ~addr for any other address.
// ----------------------------------------------------------------------------
module tb_mem_req_arbiter;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata, r2_addr, r2_wdata;
   logic        r0_ren, r0_wen, r1_ren, r1_wen, r2_ren, r2_wen;
   logic        r0_ack, r1_ack, r2_ack;
   logic [31:0] rdata;
   logic [2:0]  grant;
   logic        bus_err;
   logic [7:0]  err_count;
   logic [2:0]  ack_vec;
   logic        ack_en;

   int n_cmp = 0;
   int n_mis = 0;
   int both_hi = 0;
   int ren_rises = 0;
   logic ren_prev = 1'b0;

   mem_req_arbiter_if mbus ();

   mem_req_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ren(r0_ren), .r0_wen(r0_wen), .r0_ack(r0_ack),
      .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ren(r1_ren), .r1_wen(r1_wen), .r1_ack(r1_ack),
      .r2_addr(r2_addr), .r2_wdata(r2_wdata), .r2_ren(r2_ren), .r2_wen(r2_wen), .r2_ack(r2_ack),
      .rdata(rdata), .grant(grant), .bus_err(bus_err), .err_count(err_count),
      .mbus(mbus)
   );

   assign ack_vec = {r2_ack, r1_ack, r0_ack};

   always #5 clk = ~clk;

   function automatic logic [31:0] model_data(input logic [31:0] a);
      return (a == 32'hBFC0_0000) ? 32'h3C08_0013 : ~a;
   endfunction

   // Downstream memory-map model with one-cycle ack latency.
   always @(posedge clk) begin
      if (ack_en && (mbus.m_ren || mbus.m_wen)) begin
         mbus.m_ack   <= 1'b1;
         mbus.m_rdata <= model_data(mbus.m_addr);
      end else begin
         mbus.m_ack   <= 1'b0;
         mbus.m_rdata <= 32'h0000_0000;
      end
   end

   // Bus monitor: counts read transactions and illegal ren+wen overlap.
   always @(posedge clk) begin
      ren_prev <= mbus.m_ren;
      if (mbus.m_ren && !ren_prev) ren_rises <= ren_rises + 1;
      if (mbus.m_ren && mbus.m_wen) both_hi <= both_hi + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_ack(input logic [2:0] mask, output int cyc);
      cyc = 0;
      while (((ack_vec & mask) == 3'b000) && (cyc < 40)) begin
         @(negedge clk);
         cyc++;
      end
      if ((ack_vec & mask) == 3'b000) check("ack_wait_expired", {29'd0, ack_vec}, {29'd0, mask});
   endtask

   task automatic set_req(input int p, input logic [31:0] a, input logic ren);
      case (p)
         0:       begin r0_addr = a; r0_ren = ren; end
         1:       begin r1_addr = a; r1_ren = ren; end
         default: begin r2_addr = a; r2_ren = ren; end
      endcase
   endtask

   function automatic logic [31:0] rr_addr(input int p, input int j);
      return 32'h1000_0000 + 32'(p * 256) + 32'(j * 16);
   endfunction

   initial begin
      int cyc;
      int rises0;
      int left [3];
      int ep;

      rst = 1'b1; ack_en = 1'b1;
      r0_addr = 32'h0; r0_wdata = 32'h0; r0_ren = 1'b0; r0_wen = 1'b0;
      r1_addr = 32'h0; r1_wdata = 32'h0; r1_ren = 1'b0; r1_wen = 1'b0;
      r2_addr = 32'h0; r2_wdata = 32'h0; r2_ren = 1'b0; r2_wen = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_grant", {29'd0, grant}, 32'd0);
      check("rst_ack", {29'd0, ack_vec}, 32'd0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_mreq", {30'd0, mbus.m_ren, mbus.m_wen}, 32'd0);
      check("rst_err", {23'd0, bus_err, err_count}, 32'd0);

      // Single read from port 1
      rises0 = ren_rises;
      r1_addr = 32'hBFC0_0000; r1_ren = 1'b1;
      @(negedge clk);
      check("rd_grant", {29'd0, grant}, 32'd2);
      check("rd_mren", {30'd0, mbus.m_ren, mbus.m_wen}, 32'd2);
      check("rd_maddr", mbus.m_addr, 32'hBFC0_0000);
      wait_ack(3'b010, cyc);
      check("rd_latency", 32'(cyc + 1), 32'd5);
      check("rd_ackvec", {29'd0, ack_vec}, 32'd2);
      check("rd_rdata", rdata, 32'h3C08_0013);
      check("rd_grant_resp", {29'd0, grant}, 32'd2);
      r1_ren = 1'b0;
      @(negedge clk);
      check("rd_idle", {26'd0, ack_vec, grant}, 32'd0);
      check("rd_one_txn", 32'(ren_rises - rises0), 32'd1);

      // Single write from port 0
      r0_addr = 32'h1F80_0010; r0_wdata = 32'hDEAD_BEEF; r0_wen = 1'b1;
      @(negedge clk);
      check("wr_grant", {29'd0, grant}, 32'd1);
      check("wr_mreq", {30'd0, mbus.m_ren, mbus.m_wen}, 32'd1);
      check("wr_maddr", mbus.m_addr, 32'h1F80_0010);
      check("wr_mwdata", mbus.m_wdata, 32'hDEAD_BEEF);
      wait_ack(3'b001, cyc);
      check("wr_ackvec", {29'd0, ack_vec}, 32'd1);
      check("wr_rdata", rdata, 32'h0);
      r0_wen = 1'b0;
      @(negedge clk);
      check("wr_idle", {26'd0, ack_vec, grant}, 32'd0);

      // Port 2 asserts ren and wen together: treated as a read
      r2_addr = 32'h0000_0040; r2_wdata = 32'h0000_1234; r2_ren = 1'b1; r2_wen = 1'b1;
      @(negedge clk);
      check("rw_grant", {29'd0, grant}, 32'd4);
      check("rw_mreq", {30'd0, mbus.m_ren, mbus.m_wen}, 32'd2);
      wait_ack(3'b100, cyc);
      check("rw_rdata", rdata, 32'hFFFF_FFBF);
      r2_ren = 1'b0; r2_wen = 1'b0;
      @(negedge clk);
      check("rw_idle", {26'd0, ack_vec, grant}, 32'd0);

      // Round-robin: all ports request continuously, two reads each
      left = '{2, 2, 2};
      for (int p = 0; p < 3; p++) set_req(p, rr_addr(p, 0), 1'b1);
      for (int t = 0; t < 6; t++) begin
         ep = t % 3;
         wait_ack(3'b111, cyc);
         check("rr_ack", {29'd0, ack_vec}, 32'd1 << ep);
         check("rr_grant", {29'd0, grant}, 32'd1 << ep);
         check("rr_rdata", rdata, ~rr_addr(ep, 2 - left[ep]));
         left[ep]--;
         set_req(ep, rr_addr(ep, 2 - left[ep]), 1'b0);
         @(negedge clk);
         if (left[ep] > 0) set_req(ep, rr_addr(ep, 2 - left[ep]), 1'b1);
      end
      @(negedge clk);
      check("rr_idle", {26'd0, ack_vec, grant}, 32'd0);
      check("rr_left", 32'(left[0] + left[1] + left[2]), 32'd0);

      // Timeout: no downstream ack
      ack_en = 1'b0;
      r1_addr = 32'h2000_0000; r1_ren = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check($sformatf("to_buserr_%0d", i), {31'd0, bus_err}, (i == 5) ? 32'd1 : 32'd0);
         check($sformatf("to_mren_%0d", i), {31'd0, mbus.m_ren}, (i <= 4) ? 32'd1 : 32'd0);
         check($sformatf("to_ack_%0d", i), {29'd0, ack_vec}, (i == 6) ? 32'd2 : 32'd0);
      end
      check("to_rdata", rdata, 32'h0);
      check("to_errcnt", {24'd0, err_count}, 32'd1);
      r1_ren = 1'b0;
      @(negedge clk);
      check("to_idle", {26'd0, ack_vec, grant}, 32'd0);

      // Reset in BUSY, then port 0 must win from pointer 0
      r1_addr = 32'h3300_0000; r1_ren = 1'b1;
      @(negedge clk);
      check("mr_busy", {31'd0, mbus.m_ren}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mr_mreq", {30'd0, mbus.m_ren, mbus.m_wen}, 32'd0);
      check("mr_maddr", mbus.m_addr, 32'h0);
      check("mr_grant_ack", {26'd0, ack_vec, grant}, 32'd0);
      check("mr_err", {23'd0, bus_err, err_count}, 32'd0);
      check("mr_rdata", rdata, 32'h0);
      r1_ren = 1'b0;
      @(negedge clk);
      rst = 1'b0; ack_en = 1'b1;
      r0_addr = 32'h3000_0000; r0_ren = 1'b1;
      r2_addr = 32'h3000_0020; r2_ren = 1'b1;
      wait_ack(3'b101, cyc);
      check("mr_r0_ack", {29'd0, ack_vec}, 32'd1);
      check("mr_r0_rdata", rdata, 32'hCFFF_FFFF);
      r0_ren = 1'b0;
      @(negedge clk);
      wait_ack(3'b100, cyc);
      check("mr_r2_rdata", rdata, 32'hCFFF_FFDF);
      r2_ren = 1'b0;
      @(negedge clk);
      check("end_idle", {26'd0, ack_vec, grant}, 32'd0);
      check("no_ren_wen_overlap", 32'(both_hi), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Three-port round-robin arbiter that shares the single CPU-side memory request port (ren/wen/ack four-phase handshake into the address-decode/memory-map block) between the DMA engine (port 0), the CPU data port (port 1) and the CPU instruction-fetch port (port 2). It latches one requester's command, runs the complete downstream handshake, and returns the read data and ack to that requester. A bounded timeout aborts hung downstream transactions so no requester blocks forever.

## Interface
- TIMEOUT, 255: max cycles in BUSY waiting for m_ack before abort; legal range 1..65535.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rN_addr  in  32  port N (N=0,1,2) byte address; held stable while rN_ren/rN_wen high until rN_ack.
- rN_wdata  in  32  port N write data.
- rN_ren, rN_wen  in  1  port N read/write request (level).
- rN_ack  out  1  port N acknowledge (level, four-phase).
- rdata  out  32  read data, shared; valid while any rN_ack high.
- grant  out  3  one-hot owner of downstream port, 0 when IDLE.
- bus_err  out  1  one-cycle pulse on timeout abort.
- err_count  out  8  saturating count of timeouts.
- m_addr, m_wdata  out  32  downstream address/write data (registered).
- m_ren, m_wen  out  1  downstream request (registered).
- m_ack  in  1  downstream acknowledge (level, four-phase).
- m_rdata  in  32  downstream read data, valid when m_ack high.

## Operation
- States: IDLE, BUSY, DRAIN, RESP. Reset: state IDLE, all outputs 0, rr pointer = 0, timeout counter = 0.
- A port requests when ren|wen. If both high, it is a read (m_ren=1, m_wen=0).
- IDLE: if any port requests, select the first requester scanning ptr, ptr+1, ptr+2 (mod 3). On that edge, latch addr/wdata/ren/wen into m_* registers, set grant, go BUSY. Later changes on the granted port's inputs are ignored.
- BUSY: m_ren/m_wen high and the counter increments.
  - m_ack=1: latch m_rdata into rdata (writes latch 0), clear m_ren/m_wen, go DRAIN.
  - Counter reaches TIMEOUT-1 without m_ack: clear m_ren/m_wen, rdata=0, pulse bus_err, err_count+1 (saturate at 255), go DRAIN.
- DRAIN: wait for m_ack=0, then set the granted rN_ack=1 and go RESP. If m_ack is already 0, transition on the next edge.
- RESP: hold rN_ack and rdata. When the granted port's ren and wen are both 0, clear rN_ack, clear grant, set ptr = (granted+1) mod 3, go IDLE.
- Non-granted ports never see ack. Their requests wait in IDLE arbitration.
- Reset mid-transaction returns all outputs to 0 immediately (async). The downstream side sees m_ren/m_wen fall and must recover on its own.

## Timing
- Request first sampled high at edge k in IDLE: m_ren/m_wen and grant high after edge k.
- m_ack first high at edge d: m_ren/m_wen low after d.
- m_ack low at edge e: rN_ack high after e.
- Requester drops at edge f: rN_ack low after f, and the next arbitration is possible at edge f+1.
- Minimum turnaround with a downstream that acks 1 cycle after the request and drops 1 cycle after it: 5 cycles from request to ack, and 1 idle cycle between back-to-back grants.
- Timeout: with no m_ack, bus_err pulses TIMEOUT cycles after BUSY entry.
- rdata is stable from rN_ack rise until the next BUSY→DRAIN transition.

## Test plan
- Single read: r1 reads 0xBFC00000 and the downstream model returns 0x3C080013 → m_ren one transaction, r1_ack high with rdata=0x3C080013, grant=3'b010, then back to IDLE after r1_ren falls.
- Single write: r0 writes 0xDEADBEEF to 0x1F800010 → m_wen=1, m_addr=0x1F800010, m_wdata=0xDEADBEEF, r0_ack returned, rdata=0.
- Round-robin: all three ports request continuously with 2 reads each → grant order 0,1,2,0,1,2, and no port starves.
- Simultaneous ren & wen: r2 asserts both → downstream sees m_ren=1, m_wen=0 only.
- Timeout: TIMEOUT=4, m_ack tied 0, r1 reads → bus_err pulse 4 cycles after BUSY entry, r1_ack with rdata=0, err_count=1.
- Reset mid-op: assert rst in BUSY with m_ren=1 → all outputs 0 asynchronously. After release, a new r0 read completes normally from ptr=0.
